// File: rtl/if_id_skid_reg.sv
// IF/ID boundary: two-entry skid buffer with flush; ready_F comes only from registers.
// Optional stall counter output when IF_ID_PERF_CNT_EN is defined.
module if_id_skid_reg #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_F,
  input  logic [DATA_W-1:0] instruction_F,
  input  logic [DATA_W-1:0] PC_F,
  output logic              ready_F,
  input  logic              flush,
  output logic              valid_D,
  input  logic              ready_D,
  output logic [DATA_W-1:0] IR_D,
  output logic [DATA_W-1:0] PC_D,
`ifdef IF_ID_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [DATA_W-1:0] PC_plus4_D
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_BUSY,
    S_FULL
  } state_e;

  localparam logic [DATA_W-1:0] FOUR = DATA_W'(4);

  state_e            state_q;
  logic              main_vld_q;
  logic [DATA_W-1:0] main_ir_q;
  logic [DATA_W-1:0] main_pc_q;
  logic [DATA_W-1:0] main_pc4_q;
  logic              skid_vld_q;
  logic [DATA_W-1:0] skid_ir_q;
  logic [DATA_W-1:0] skid_pc_q;

  logic              accept;
  logic              consume;
  logic [DATA_W-1:0] in_pc4_d;
  logic [DATA_W-1:0] skid_pc4_d;

  assign ready_F    = ~skid_vld_q;
  assign valid_D    = main_vld_q;
  assign IR_D       = main_ir_q;
  assign PC_D       = main_pc_q;
  assign PC_plus4_D = main_pc4_q;

  // Handshake qualifiers and PC+4 for whichever beat is captured into main.
  always_comb begin
    accept     = valid_F & ready_F;
    consume    = main_vld_q & ready_D;
    in_pc4_d   = PC_F + FOUR;
    skid_pc4_d = skid_pc_q + FOUR;
  end

  // Occupancy FSM moving beats through main and skid in FIFO order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= S_EMPTY;
      main_vld_q <= 1'b0;
      main_ir_q  <= NOP_INSTR;
      main_pc_q  <= RESET_PC;
      main_pc4_q <= RESET_PC + FOUR;
      skid_vld_q <= 1'b0;
      skid_ir_q  <= '0;
      skid_pc_q  <= '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_q    <= S_BUSY;
            main_vld_q <= 1'b1;
            main_ir_q  <= instruction_F;
            main_pc_q  <= PC_F;
            main_pc4_q <= in_pc4_d;
          end
        end
        S_BUSY: begin
          if (accept && consume) begin
            main_ir_q  <= instruction_F;
            main_pc_q  <= PC_F;
            main_pc4_q <= in_pc4_d;
          end else if (accept) begin
            state_q    <= S_FULL;
            skid_vld_q <= 1'b1;
            skid_ir_q  <= instruction_F;
            skid_pc_q  <= PC_F;
          end else if (consume) begin
            state_q    <= S_EMPTY;
            main_vld_q <= 1'b0;
          end
        end
        S_FULL: begin
          if (consume) begin
            state_q    <= S_BUSY;
            main_ir_q  <= skid_ir_q;
            main_pc_q  <= skid_pc_q;
            main_pc4_q <= skid_pc4_d;
            skid_vld_q <= 1'b0;
            skid_ir_q  <= '0;
            skid_pc_q  <= '0;
          end
        end
        default: begin
          state_q    <= S_EMPTY;
          main_vld_q <= 1'b0;
          skid_vld_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // Saturating count of cycles decode holds back a live beat; flush keeps it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (main_vld_q && !ready_D && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed cases then random traffic
// against a queue-based reference model.
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_F;
  logic [31:0] instruction_F;
  logic [31:0] PC_F;
  logic        ready_F;
  logic        flush;
  logic        valid_D;
  logic        ready_D;
  logic [31:0] IR_D;
  logic [31:0] PC_D;
  logic [31:0] PC_plus4_D;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] q_ir[$];
  logic [31:0] q_pc[$];
  logic [31:0] m_ir;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk           (clk),
    .rst           (rst),
    .valid_F       (valid_F),
    .instruction_F (instruction_F),
    .PC_F          (PC_F),
    .ready_F       (ready_F),
    .flush         (flush),
    .valid_D       (valid_D),
    .ready_D       (ready_D),
    .IR_D          (IR_D),
    .PC_D          (PC_D),
`ifdef IF_ID_PERF_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .PC_plus4_D    (PC_plus4_D)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid_D"}, 32'(valid_D), 32'(q_ir.size() > 0));
    chk({tag, ".ready_F"}, 32'(ready_F), 32'(q_ir.size() < 2));
    chk({tag, ".IR_D"}, IR_D, m_ir);
    chk({tag, ".PC_D"}, PC_D, m_pc);
    chk({tag, ".PC4"}, PC_plus4_D, m_pc + 32'd4);
`ifdef IF_ID_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_cnt);
`endif
  endtask

  task automatic model_reset();
    q_ir.delete();
    q_pc.delete();
    m_ir  = 32'h0;
    m_pc  = 32'h0;
    m_cnt = 32'h0;
  endtask

  // Called just after a negedge: drive one cycle, advance model, check.
  task automatic drive(input string tag, input logic r, input logic v,
                       input logic [31:0] ir, input logic [31:0] pc,
                       input logic rd, input logic fl);
    bit vld;
    bit rdy;
    rst = r;
    valid_F = v;
    instruction_F = ir;
    PC_F = pc;
    ready_D = rd;
    flush = fl;
    vld = q_ir.size() > 0;
    rdy = q_ir.size() < 2;
    if (r) begin
      model_reset();
    end else begin
      if (vld && !rd && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (fl) begin
        q_ir.delete();
        q_pc.delete();
        m_ir = 32'h0;
        m_pc = 32'h0;
      end else begin
        if (vld && rd) begin
          void'(q_ir.pop_front());
          void'(q_pc.pop_front());
        end
        if (v && rdy) begin
          q_ir.push_back(ir);
          q_pc.push_back(pc);
        end
        if (q_ir.size() > 0) begin
          m_ir = q_ir[0];
          m_pc = q_pc[0];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    valid_F = 1'b0;
    instruction_F = '0;
    PC_F = '0;
    ready_D = 1'b0;
    flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all("reset");
    chk("reset.PC4_abs", PC_plus4_D, 32'd4);

    drive("stream0", 0, 1, 32'hA000_0001, 32'h0, 1, 0);
    drive("stream4", 0, 1, 32'hA000_0002, 32'h4, 1, 0);
    drive("stream8", 0, 1, 32'hA000_0003, 32'h8, 1, 0);
    drive("drain", 0, 0, 32'h0, 32'h0, 1, 0);

    drive("skidA", 0, 1, 32'hBBBB_000A, 32'h10, 0, 0);
    drive("skidB", 0, 1, 32'hBBBB_000B, 32'h14, 0, 0);
    chk("full.ready_F", 32'(ready_F), 32'd0);
    drive("fullhold", 0, 1, 32'hDEAD_BEEF, 32'h18, 0, 0);
    drive("outA", 0, 0, 32'h0, 32'h0, 1, 0);
    chk("outB.PC", PC_D, 32'h14);
    drive("outB", 0, 0, 32'h0, 32'h0, 1, 0);

    drive("fillA", 0, 1, 32'hCCCC_000A, 32'h20, 0, 0);
    drive("fillB", 0, 1, 32'hCCCC_000B, 32'h24, 0, 0);
    drive("flushC", 0, 1, 32'hCCCC_000C, 32'h28, 0, 1);
    chk("flush.valid", 32'(valid_D), 32'd0);
    drive("postflush", 0, 0, 32'h0, 32'h0, 1, 0);

    drive("wrap", 0, 1, 32'h1234_5678, 32'hFFFF_FFFC, 1, 0);
    chk("wrap.PC4_abs", PC_plus4_D, 32'h0);
    drive("wrapdrain", 0, 0, 32'h0, 32'h0, 1, 0);

    drive("cntrst", 1, 0, 32'h0, 32'h0, 0, 0);
    drive("cntload", 0, 1, 32'h5555_0001, 32'h40, 0, 0);
    for (int i = 0; i < 7; i++) drive("stall", 0, 0, 32'h0, 32'h0, 0, 0);
`ifdef IF_ID_PERF_CNT_EN
    chk("stall7", stall_cnt, 32'd7);
`endif
    drive("cntflush", 0, 0, 32'h0, 32'h0, 1, 1);
`ifdef IF_ID_PERF_CNT_EN
    chk("stall7.flush", stall_cnt, 32'd7);
`endif

    for (int i = 0; i < 3000; i++) begin
      drive("rand",
            ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom(),
            ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & ~32'h3),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
